// File: rtl/mac_stream.sv
`default_nettype none
// ============================================================================
// Module      : mac_stream
// Description : Streaming multiply-accumulate engine. Operand pairs arrive on
//               a valid/ready handshake, pass through a registered multiplier
//               and are summed into groups closed by 'last'. Each completed
//               dot product is held with its sample count and a sticky
//               overflow flag until the consumer takes it.
// Options     : define MAC_STREAM_SAT_EN to clamp the accumulator on overflow
//               (default build wraps modulo 2^ACC_W).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mac_stream #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 10,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              ovf_out
);

    // Group state. HOLD coincides exactly with a result sitting on the output:
    // the accumulator is always cleared on the edge that loads a result.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    // Stage 1: captured operands
    logic                r_s1_valid;
    logic                r_s1_last;
    logic [DATA_W-1:0]   r_s1_a;
    logic [DATA_W-1:0]   r_s1_b;

    // Stage 2: registered product
    logic                r_s2_valid;
    logic                r_s2_last;
    logic [2*DATA_W-1:0] r_s2_prod;

    // Stage 3: running group and held result
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic [ACC_W-1:0]    r_res_acc;
    logic [CNT_W-1:0]    r_res_cnt;
    logic                r_res_ovf;

    logic                w_adv;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    w_base_acc;
    logic [CNT_W-1:0]    w_base_cnt;
    logic                w_base_ovf;
    logic [ACC_W:0]      w_sum;
    logic                w_step_oor;
    logic [ACC_W-1:0]    w_step_acc;
    logic [CNT_W-1:0]    w_step_cnt;
    logic                w_step_ovf;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_ovf_nxt;
    logic                w_res_load;
`ifdef MAC_STREAM_SAT_EN
    logic [ACC_W-1:0]    w_clamp;
`endif

    // The whole pipeline freezes only while a result is held and not taken.
    assign out_valid = (r_state == c_ST_HOLD);
    assign w_adv     = !(out_valid && !out_ready);
    assign in_ready  = w_adv;
    assign acc_out   = r_res_acc;
    assign cnt_out   = r_res_cnt;
    assign ovf_out   = r_res_ovf;

    // A group always starts from zero, whether coming from IDLE or HOLD.
    assign w_base_acc = (r_state == c_ST_ACCUM) ? r_acc : '0;
    assign w_base_cnt = (r_state == c_ST_ACCUM) ? r_cnt : '0;
    assign w_base_ovf = (r_state == c_ST_ACCUM) ? r_ovf : 1'b0;

    // Operand extension, product extension and range test depend on signedness.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_prod     = {{DATA_W{r_s1_a[DATA_W-1]}}, r_s1_a}
                              * {{DATA_W{r_s1_b[DATA_W-1]}}, r_s1_b};
            assign w_prod_ext = ACC_W'($signed(r_s2_prod));
            assign w_sum      = {w_base_acc[ACC_W-1], w_base_acc}
                              + {w_prod_ext[ACC_W-1], w_prod_ext};
            // Sign bits disagree when the true sum leaves the ACC_W range.
            assign w_step_oor = w_sum[ACC_W] ^ w_sum[ACC_W-1];
`ifdef MAC_STREAM_SAT_EN
            assign w_clamp    = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                             : {1'b0, {(ACC_W-1){1'b1}}};
`endif
        end else begin : g_unsigned
            assign w_prod     = {{DATA_W{1'b0}}, r_s1_a} * {{DATA_W{1'b0}}, r_s1_b};
            assign w_prod_ext = ACC_W'(r_s2_prod);
            assign w_sum      = {1'b0, w_base_acc} + {1'b0, w_prod_ext};
            assign w_step_oor = w_sum[ACC_W];
`ifdef MAC_STREAM_SAT_EN
            assign w_clamp    = {ACC_W{1'b1}};
`endif
        end
    endgenerate

`ifdef MAC_STREAM_SAT_EN
    assign w_step_acc = w_step_oor ? w_clamp : w_sum[ACC_W-1:0];
`else
    assign w_step_acc = w_sum[ACC_W-1:0];
`endif
    assign w_step_cnt = (&w_base_cnt) ? w_base_cnt : w_base_cnt + CNT_W'(1);
    assign w_step_ovf = w_base_ovf | w_step_oor;

    // Operand and product pipeline, advancing in lockstep with the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_prod  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_last  <= last;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_prod  <= w_prod;
        end
    end

    // Group FSM next state and accumulator update.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_res_load  = 1'b0;
        if (w_adv) begin
            if (r_s2_valid) begin
                if (r_s2_last) begin
                    w_state_nxt = c_ST_HOLD;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_res_load  = 1'b1;
                end else begin
                    w_state_nxt = c_ST_ACCUM;
                    w_acc_nxt   = w_step_acc;
                    w_cnt_nxt   = w_step_cnt;
                    w_ovf_nxt   = w_step_ovf;
                end
            end else if (r_state == c_ST_HOLD) begin
                w_state_nxt = c_ST_IDLE;
            end
        end
    end

    // Group state, running sum and held result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_res_acc <= '0;
            r_res_cnt <= '0;
            r_res_ovf <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            if (w_res_load) begin
                r_res_acc <= w_step_acc;
                r_res_cnt <= w_step_cnt;
                r_res_ovf <= w_step_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_stream
// Description : Self-checking bench for mac_stream. An unsigned and a signed
//               instance share one stimulus stream; results are compared with
//               an arithmetic reference model (define MAC_STREAM_SAT_EN to
//               target the saturating build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_stream;

    typedef struct packed {
        logic [9:0] acc;
        logic [7:0] cnt;
        logic       ovf;
    } res_t;

`ifdef MAC_STREAM_SAT_EN
    localparam bit c_SAT = 1'b1;
`else
    localparam bit c_SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       last;
    logic       out_ready;

    logic       in_ready,  out_valid,  ovf_out;
    logic [9:0] acc_out;
    logic [7:0] cnt_out;
    logic       in_ready_s, out_valid_s, ovf_out_s;
    logic [9:0] acc_out_s;
    logic [7:0] cnt_out_s;

    int errors = 0;
    int checks = 0;
    bit rand_bp = 1'b0;

    res_t   exp_q[$];
    res_t   exp_qs[$];
    longint m_acc [2];
    bit     m_ovf [2];
    int     m_cnt;

    always #5 clk = ~clk;

    mac_stream #(.DATA_W(4), .ACC_W(10), .CNT_W(8), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .last(last), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .cnt_out(cnt_out), .ovf_out(ovf_out)
    );

    mac_stream #(.DATA_W(4), .ACC_W(10), .CNT_W(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .last(last), .out_valid(out_valid_s), .out_ready(out_ready),
        .acc_out(acc_out_s), .cnt_out(cnt_out_s), .ovf_out(ovf_out_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint opval(input logic [3:0] x, input bit sgn);
        return sgn ? longint'($signed(x)) : longint'(x);
    endfunction

    task automatic model_clear();
        m_acc[0] = 0; m_acc[1] = 0;
        m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
        m_cnt = 0;
        exp_q.delete();
        exp_qs.delete();
    endtask

    // Reference: exact integer sum per step, then range test, wrap or clamp.
    task automatic model_accept(input logic [3:0] ta, input logic [3:0] tb, input logic tl);
        for (int s = 0; s < 2; s++) begin
            longint p, sum, lo, hi;
            p   = opval(ta, s != 0) * opval(tb, s != 0);
            sum = m_acc[s] + p;
            lo  = (s != 0) ? -512 : 0;
            hi  = (s != 0) ? 511 : 1023;
            if (sum < lo || sum > hi) begin
                m_ovf[s] = 1'b1;
                if (c_SAT) sum = (sum > hi) ? hi : lo;
                else       sum = (((sum - lo) % 1024) + 1024) % 1024 + lo;
            end
            m_acc[s] = sum;
        end
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (tl) begin
            exp_q.push_back(res_t'{10'(m_acc[0]), 8'(m_cnt), m_ovf[0]});
            exp_qs.push_back(res_t'{10'(m_acc[1]), 8'(m_cnt), m_ovf[1]});
            m_acc[0] = 0; m_acc[1] = 0;
            m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
            m_cnt = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic tl);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; a = ta; b = tb; last = tl;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk);
            model_accept(ta, tb, tl);
            #1;
        end else begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget; t++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_acc_out",   32'(acc_out),   32'd0);
        check("rst_cnt_out",   32'(cnt_out),   32'd0);
        check("rst_ovf_out",   32'(ovf_out),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_s_out_valid", 32'(out_valid_s), 32'd0);
        check("rst_s_acc_out",   32'(acc_out_s),   32'd0);
        check("rst_s_in_ready",  32'(in_ready_s),  32'd1);
    endtask

    // Result scoreboard: every consumed result must match the model, in order.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0 || exp_qs.size() == 0) begin
                check("spurious_result", 32'(exp_q.size() != 0 && exp_qs.size() != 0), 32'd1);
            end else begin
                res_t e, es;
                e  = exp_q.pop_front();
                es = exp_qs.pop_front();
                check("acc_out",     32'(acc_out),     32'(e.acc));
                check("cnt_out",     32'(cnt_out),     32'(e.cnt));
                check("ovf_out",     32'(ovf_out),     32'(e.ovf));
                check("s_out_valid", 32'(out_valid_s), 32'd1);
                check("s_acc_out",   32'(acc_out_s),   32'(es.acc));
                check("s_cnt_out",   32'(cnt_out_s),   32'(es.cnt));
                check("s_ovf_out",   32'(ovf_out_s),   32'(es.ovf));
            end
        end
    end

    // Random backpressure during the random phase only.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; last = 1'b0; out_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset mid-group with pairs in flight
        send(4'd7, 4'd7, 1'b0);
        send(4'd7, 4'd7, 1'b0);
        send(4'd9, 4'd9, 1'b0);
        rst = 1'b0;
        #1;
        check_reset();
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset while a result is held
        out_ready = 1'b0;
        send(4'd1, 4'd1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check_reset();
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;

        send(4'd3, 4'd5, 1'b1);
        drain(50);

        // Back-to-back 4x(15,15) with latency check
        send(4'd15, 4'd15, 1'b0);
        send(4'd15, 4'd15, 1'b0);
        send(4'd15, 4'd15, 1'b0);
        send(4'd15, 4'd15, 1'b1);
        @(negedge clk);
        check("lat_edge_k",  32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_edge_k1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_edge_k2", 32'(out_valid), 32'd1);
        check("lat_acc_900", 32'(acc_out),   32'd900);
        @(posedge clk); #1;
        drain(50);

        // Overflow: 5x(15,15)
        for (int i = 0; i < 5; i++) send(4'd15, 4'd15, i == 4);
        drain(50);

        // Signed pattern (-8,-8),(-8,7),(3,-2)
        send(4'h8, 4'h8, 1'b0);
        send(4'h8, 4'h7, 1'b0);
        send(4'h3, 4'hE, 1'b1);
        drain(50);

        // Backpressure: three single-pair groups held behind out_ready=0
        out_ready = 1'b0;
        send(4'd1, 4'd1, 1'b1);
        send(4'd2, 4'd2, 1'b1);
        send(4'd3, 4'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_acc_out",   32'(acc_out),   32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain(50);

        // Bubbles inside a group
        send(4'd2, 4'd3, 1'b0);
        idle_cycle();
        idle_cycle();
        send(4'd4, 4'd5, 1'b1);
        drain(50);

        // Count saturation: 300 pairs in one group
        for (int i = 0; i < 300; i++) send(4'd1, 4'd1, i == 299);
        drain(50);

        // Random groups, operands, bubbles and backpressure
        rand_bp = 1'b1;
        for (int g = 0; g < 40; g++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) idle_cycle();
                send(4'($urandom), 4'($urandom), i == len - 1);
            end
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain(500);
        check("final_s_pending", 32'(exp_qs.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_stream.md
# mac_stream

Parametrised streaming multiply-accumulate engine, the next generation of the team's fixed 4-bit MAC. It accepts operand pairs over a valid/ready handshake and multiplies them in a registered pipeline. Products are accumulated into groups delimited by a `last` flag, and each completed dot product is presented with its sample count and an overflow flag. It sits between operand sources (filter taps, matrix rows) and any consumer that can apply backpressure.

## Interface
- `DATA_W`, default 4: operand width.
- `ACC_W`, default 10: accumulator and result width; must be ≥ 2*DATA_W.
- `CNT_W`, default 8: sample-count width.
- `SIGNED`, default 0:
  - 0: operands and product are unsigned.
  - 1: operands and product are two's complement.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  engine can accept a pair this cycle.
- `a`, `b`  in  DATA_W  operands.
- `last`  in  1  this pair closes the current group.
- `out_valid`  out  1  result held on the output.
- `out_ready`  in  1  consumer takes the result.
- `acc_out`  out  ACC_W  completed dot product.
- `cnt_out`  out  CNT_W  number of pairs in the group; saturates at 2^CNT_W-1.
- `ovf_out`  out  1  group exceeded the ACC_W range at least once.

## Operation
- Transfer occurs when `in_valid && in_ready`.
- Pipeline has three stages, all enabled by a common `adv = !(out_valid && !out_ready)`. `in_ready = adv`.
  - S1 registers `a`, `b`, `last`, and a valid bit.
  - S2 registers the 2*DATA_W product, the `last` tag and the valid bit.
  - S3 is the accumulator.
- Width rules:
  - Product is sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W.
  - `cnt` increments by 1 per product and holds at all-ones.
- Group FSM is held in S3:
  - IDLE: no open group; acc=0, cnt=0.
    - A valid product without `last` → ACCUM with acc=prod, cnt=1.
    - A valid product with `last` → HOLD with a result of prod, cnt 1.
  - ACCUM: each valid product sets acc=acc+prod and cnt+1.
    - Product with `last` → HOLD; the output register loads acc+prod, cnt+1 and the OR'd overflow.
    - Accumulator clears to 0 and returns to a free state in the same edge.
  - HOLD: `out_valid`=1 and outputs are stable.
    - `out_ready` → IDLE, or straight to the next result if one is loaded on the same edge.
    - While `out_ready`=0, `adv`=0: nothing moves and in-flight pairs are retained.
- Simultaneous events:
  - Result consumed and new `last` product arriving on the same edge: the output reloads and `out_valid` stays 1.
  - A pair accepted on the same edge a result is consumed enters S1 normally.
- Overflow: the sum is computed at ACC_W+1 bits, with signed or unsigned range test per SIGNED. Any out-of-range step sets the sticky group flag; the flag clears when the group closes.
- Bubbles (in_valid=0) propagate as invalid stages and do not alter acc or cnt.

## Timing
- Reset (async, while `rst`=0):
  - all stage valids=0, FSM=IDLE, acc=0, cnt=0.
  - `out_valid`=0, `acc_out`=0, `cnt_out`=0, `ovf_out`=0, `in_ready`=1.
- Reset asserted mid-group or while in HOLD discards everything. There is no partial-result output.
- Latency: `last` pair accepted on edge k → `out_valid` rises on edge k+2 (visible in cycle k+3), assuming no stall.
- Throughput: one pair per cycle; one result per cycle when groups have length 1 and `out_ready`=1.
- `in_ready` is combinational from `out_valid` and `out_ready` only, with no path from `in_valid`.

## Configuration
- `MAC_STREAM_SAT_EN` defined:
  - An out-of-range step clamps acc to the max or min of the ACC_W range (unsigned: 0..2^ACC_W-1; signed: -2^(ACC_W-1)..2^(ACC_W-1)-1).
  - Later steps continue from the clamped value.
  - `ovf_out` is still set.
- Undefined: the accumulator wraps modulo 2^ACC_W and `ovf_out` is set.

## Test plan
- Reset: drive `rst`=0 mid-group with pairs in flight, release it → all outputs 0 and `in_ready`=1; the next group of (3,5),last gives `acc_out`=15, `cnt_out`=1.
- Default unsigned: 4 pairs (15,15), last on the 4th, back-to-back → `acc_out`=900, `cnt_out`=4, `ovf_out`=0, `out_valid` 2 edges after the last accept.
- Overflow: 5×(15,15) → wrap build gives `acc_out`=101 and `ovf_out`=1; `MAC_STREAM_SAT_EN` build gives 1023 and `ovf_out`=1.
- Signed (SIGNED=1): (-8,-8),(-8,7),(3,-2) with last → `acc_out`=2 (10'h002), `cnt_out`=3, `ovf_out`=0.
- Backpressure: three single-pair groups (1,1),(2,2),(3,3) with `out_ready`=0 for 5 cycles → `in_ready`=0 while the first result is held, no loss; on release the results 1, 4, 9 arrive in order.
- Bubbles: (2,3),idle,idle,(4,5) with last → `acc_out`=26, `cnt_out`=2.
